// File: rtl/duty_cycle_scheduler.sv
// Sequences a duty-cycle measurement circuit across up to four ring oscillators:
// clear, settle, measure for a fixed window, then capture the result per channel.
module duty_cycle_scheduler #(
   parameter int unsigned SETTLE_CYC = 16,
   parameter int unsigned WINDOW_CYC = 256
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] ring_in,
   input  logic [3:0] ch_mask,
   input  logic       start,
   input  logic       continuous,
   input  logic       abort,
   input  logic [7:0] meas_value,
   output logic       ring_sel,
   output logic       meas_enable,
   output logic       meas_clear,
   output logic [7:0] result,
   output logic [1:0] result_ch,
   output logic       result_valid,
   output logic       busy,
   output logic       sweep_done
);

   localparam int unsigned MaxCyc = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
   localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

   localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYC - 1);
   localparam logic [CntW-1:0] WindowLoad = CntW'(WINDOW_CYC - 1);

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StSettle,
      StMeasure,
      StCapture,
      StAdvance
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      cur_ch_q, cur_ch_d;
   logic [3:0]      mask_q, mask_d;
   logic [7:0]      result_q, result_d;
   logic [1:0]      result_ch_q, result_ch_d;
   logic            valid_d, done_d;
   logic [3:0]      above;
   logic            has_next;

   function automatic logic [1:0] lowest_bit(input logic [3:0] m);
      logic [1:0] idx;
      casez (m)
         4'b???1: idx = 2'd0;
         4'b??10: idx = 2'd1;
         4'b?100: idx = 2'd2;
         default: idx = 2'd3;
      endcase
      return idx;
   endfunction

   // Channels of the latched mask strictly above the current one.
   always_comb begin
      above    = mask_q & (4'b1110 << cur_ch_q);
      has_next = |above;
   end

   assign ring_sel = ring_in[cur_ch_q];

   always_comb begin
      state_d     = state_q;
      cnt_d       = '0;
      cur_ch_d    = cur_ch_q;
      mask_d      = mask_q;
      result_d    = result_q;
      result_ch_d = result_ch_q;
      valid_d     = 1'b0;
      done_d      = 1'b0;
      if (state_q != StIdle && abort) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start && !abort && ch_mask != 4'b0000) begin
                  mask_d   = ch_mask;
                  cur_ch_d = lowest_bit(ch_mask);
                  state_d  = StClear;
               end
            end
            StClear: begin
               cnt_d   = SettleLoad;
               state_d = StSettle;
            end
            StSettle: begin
               if (cnt_q == '0) begin
                  cnt_d   = WindowLoad;
                  state_d = StMeasure;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            StMeasure: begin
               if (cnt_q == '0) begin
                  state_d = StCapture;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            StCapture: begin
               result_d    = meas_value;
               result_ch_d = cur_ch_q;
               valid_d     = 1'b1;
               state_d     = StAdvance;
            end
            StAdvance: begin
               if (has_next) begin
                  cur_ch_d = lowest_bit(above);
                  state_d  = StClear;
               end else begin
                  done_d = 1'b1;
                  if (continuous && ch_mask != 4'b0000) begin
                     mask_d   = ch_mask;
                     cur_ch_d = lowest_bit(ch_mask);
                     state_d  = StClear;
                  end else begin
                     state_d = StIdle;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Outputs are registered from the next state so they align with the state they describe.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         cur_ch_q     <= 2'd0;
         mask_q       <= 4'b0000;
         result_q     <= 8'h00;
         result_ch_q  <= 2'd0;
         meas_enable  <= 1'b0;
         meas_clear   <= 1'b0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
         sweep_done   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cur_ch_q     <= cur_ch_d;
         mask_q       <= mask_d;
         result_q     <= result_d;
         result_ch_q  <= result_ch_d;
         meas_enable  <= (state_d == StMeasure);
         meas_clear   <= (state_d == StClear);
         result_valid <= valid_d;
         busy         <= (state_d != StIdle);
         sweep_done   <= done_d;
      end
   end

   assign result    = result_q;
   assign result_ch = result_ch_q;

endmodule

// File: tb/tb_duty_cycle_scheduler.sv
// Directed bench for duty_cycle_scheduler with SETTLE_CYC=4, WINDOW_CYC=8 (15-cycle channel period).
module tb_duty_cycle_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] ring_in;
   logic [3:0] ch_mask;
   logic       start;
   logic       continuous;
   logic       abort;
   logic [7:0] meas_value;
   logic       ring_sel;
   logic       meas_enable;
   logic       meas_clear;
   logic [7:0] result;
   logic [1:0] result_ch;
   logic       result_valid;
   logic       busy;
   logic       sweep_done;

   int total = 0;
   int bad   = 0;

   duty_cycle_scheduler #(
      .SETTLE_CYC(4),
      .WINDOW_CYC(8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ring_in     (ring_in),
      .ch_mask     (ch_mask),
      .start       (start),
      .continuous  (continuous),
      .abort       (abort),
      .meas_value  (meas_value),
      .ring_sel    (ring_sel),
      .meas_enable (meas_enable),
      .meas_clear  (meas_clear),
      .result      (result),
      .result_ch   (result_ch),
      .result_valid(result_valid),
      .busy        (busy),
      .sweep_done  (sweep_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Walks one channel period; entered at the negedge just after the CLEAR edge,
   // returns at the negedge just after the following CLEAR/IDLE edge.
   task automatic chan(input logic [1:0] ch, input logic [7:0] v, input logic done_first,
                       input logic poke);
      meas_value = v;
      for (int k = 1; k <= 15; k++) begin
         check("busy", busy, 1'b1);
         check("meas_clear", meas_clear, (k == 1));
         check("meas_enable", meas_enable, (k >= 6 && k <= 13));
         check("result_valid", result_valid, (k == 15));
         check("sweep_done", sweep_done, (k == 1) && done_first);
         if (k == 10) begin
            ring_in = 4'($urandom_range(0, 15));
            #1;
            check("ring_sel", ring_sel, ring_in[ch]);
         end
         if (k == 15) begin
            check("result", result, v);
            check("result_ch", result_ch, ch);
         end
         start = poke && (k == 5);
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   initial begin
      reset      = 1'b0;
      ring_in    = 4'b0000;
      ch_mask    = 4'b0000;
      start      = 1'b0;
      continuous = 1'b0;
      abort      = 1'b0;
      meas_value = 8'h00;
      @(negedge clk);
      @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_en", meas_enable, 1'b0);
      check("rst_clr", meas_clear, 1'b0);
      check("rst_result", result, 8'h00);
      check("rst_result_ch", result_ch, 2'd0);
      check("rst_valid", result_valid, 1'b0);
      check("rst_done", sweep_done, 1'b0);
      reset = 1'b1;
      @(negedge clk);

      // Single channel 2
      ch_mask = 4'b0100;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chan(2'd2, 8'h55, 1'b0, 1'b0);
      check("single_done", sweep_done, 1'b1);
      check("single_idle", busy, 1'b0);
      check("single_clr", meas_clear, 1'b0);
      @(negedge clk);
      check("single_done_pulse", sweep_done, 1'b0);
      check("single_hold", result, 8'h55);
      check("single_hold_ch", result_ch, 2'd2);

      // Multi-channel 1011; mask change mid-sweep and start while busy are ignored
      ch_mask = 4'b1011;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      ch_mask = 4'b0100;
      chan(2'd0, 8'hA1, 1'b0, 1'b1);
      chan(2'd1, 8'hB2, 1'b0, 1'b0);
      chan(2'd3, 8'hC3, 1'b0, 1'b0);
      check("multi_done", sweep_done, 1'b1);
      check("multi_idle", busy, 1'b0);
      @(negedge clk);
      check("multi_one_done", sweep_done, 1'b0);

      // Continuous on channel 0, then drop continuous
      continuous = 1'b1;
      ch_mask    = 4'b0001;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chan(2'd0, 8'h11, 1'b0, 1'b0);
      chan(2'd0, 8'h22, 1'b1, 1'b0);
      continuous = 1'b0;
      chan(2'd0, 8'h33, 1'b1, 1'b0);
      check("cont_done", sweep_done, 1'b1);
      check("cont_idle", busy, 1'b0);

      // Abort at MEASURE cycle 3 on channel 3
      ch_mask = 4'b1000;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k < 8; k++) @(negedge clk);
      check("abort_pre_en", meas_enable, 1'b1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_idle", busy, 1'b0);
      check("abort_en", meas_enable, 1'b0);
      check("abort_valid", result_valid, 1'b0);
      check("abort_result", result, 8'h33);
      check("abort_result_ch", result_ch, 2'd0);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         check("abort_no_valid", result_valid, 1'b0);
         check("abort_no_done", sweep_done, 1'b0);
      end

      // Abort and start together in IDLE
      ch_mask = 4'b0001;
      start   = 1'b1;
      abort   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("abort_start_busy", busy, 1'b0);
      check("abort_start_clr", meas_clear, 1'b0);

      // Start with empty mask
      ch_mask = 4'b0000;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("empty_mask_busy", busy, 1'b0);
      @(negedge clk);
      check("empty_mask_clr", meas_clear, 1'b0);

      // Reset mid-SETTLE
      ch_mask = 4'b0010;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_busy", busy, 1'b1);
      reset = 1'b0;
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_en", meas_enable, 1'b0);
      check("mid_rst_clr", meas_clear, 1'b0);
      check("mid_rst_result", result, 8'h00);
      check("mid_rst_result_ch", result_ch, 2'd0);
      check("mid_rst_valid", result_valid, 1'b0);
      check("mid_rst_done", sweep_done, 1'b0);
      ring_in = 4'b0101;
      #1;
      check("mid_rst_ring_sel", ring_sel, 1'b1);
      for (int k = 0; k < 16; k++) @(negedge clk);
      check("post_rst_idle", busy, 1'b0);
      check("post_rst_valid", result_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
